reduction_stream: RTL and testbench

- Parametrised streaming FP16 reduction unit, successor to the fixed 3-input tile accumulator.
- Each beat carries NUM_IN operand vectors of TILE_SIZE lanes. These are summed per lane through a registered fp16_add tree, then accumulated onto a per-lane running sum.
- A programmed-length reduction (len_i beats) is presented once on a valid/ready output handshake.
- Sits between the tile datapath and the writeback stage.

---
 rtl/reduction_stream.sv | 176 +++++++++++++++++
 tb/tb_reduction_stream.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/reduction_stream.sv
// Streaming FP16 reduction: NUM_IN operand vectors per beat are summed per lane through a
// registered pairwise adder tree, then accumulated onto a running per-lane sum over len_i beats.
//   state | meaning
//   IDLE  | waiting for start_i
//   ACCUM | accepting beats until beat_cnt_o reaches the stored length
//   DRAIN | input closed, folding remaining tree outputs into the accumulator
//   HOLD  | result presented on out_valid_o until consumed
module reduction_stream #(
  parameter int TILE_SIZE = 129,
  parameter int NUM_IN    = 4,
  parameter int LEN_W     = 16,
  localparam int WIDTH    = 16
) (
  input  logic                              CLK_i,
  input  logic                              RST_ni,
  input  logic                              clear_i,
  input  logic                              start_i,
  input  logic [LEN_W-1:0]                  len_i,
  input  logic [TILE_SIZE*WIDTH-1:0]        init_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
  input  logic [NUM_IN*TILE_SIZE*WIDTH-1:0] operand_i,
  output logic                              out_valid_o,
  input  logic                              out_ready_i,
  output logic [TILE_SIZE*WIDTH-1:0]        reduction_o,
  output logic                              busy_o,
  output logic [LEN_W-1:0]                  beat_cnt_o
);
  localparam int L = $clog2(NUM_IN);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  // Round-to-nearest-even FP16 add; NaN results are the canonical quiet NaN.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic [4:0]  ex, ey, d5;
    logic [13:0] mx, my, ys;
    logic [14:0] s;
    logic [5:0]  e;
    logic [11:0] m;
    logic        up, nan_a, nan_b, inf_a, inf_b;
    nan_a = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
    nan_b = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
    inf_a = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
    inf_b = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
    if (a[14:0] < b[14:0]) begin x = b; y = a; end
    else begin x = a; y = b; end
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {x[14:10] != 5'd0, x[9:0], 3'b000};
    ys = {y[14:10] != 5'd0, y[9:0], 3'b000};
    d5 = ex - ey;
    if (d5 >= 5'd14) my = {13'd0, |ys};
    else my = (ys >> d5) | {13'd0, |(ys & ((14'd1 << d5) - 14'd1))};
    e = {1'b0, ex};
    if (x[15] == y[15]) s = {1'b0, mx} + {1'b0, my};
    else s = {1'b0, mx} - {1'b0, my};
    if (s[14]) begin
      s = {1'b0, s[14:1]} | {14'd0, s[0]};
      e = e + 1'b1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13] && (e > 6'd1)) begin
        s = s << 1;
        e = e - 1'b1;
      end
    end
    up = s[2] & (s[1] | s[0] | s[3]);
    m  = {1'b0, s[13:3]} + {11'd0, up};
    if (m[11]) begin
      m = m >> 1;
      e = e + 1'b1;
    end
    if (s == 15'd0)    r = {x[15] & y[15], 15'd0};
    else if (e >= 6'd31) r = {x[15], 5'h1f, 10'd0};
    else               r = {x[15], m[10] ? e[4:0] : 5'd0, m[9:0]};
    if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) r = 16'h7e00;
    else if (inf_a) r = a;
    else if (inf_b) r = b;
    return r;
  endfunction

  logic [1:0]                 state;
  logic [LEN_W-1:0]           len_q;
  logic [TILE_SIZE*WIDTH-1:0] acc, acc_sum;
  logic [L:0]                 vld;
  logic                       accept;
  logic [LEN_W-1:0]           cnt_inc;

  assign in_ready_o  = (state == ACCUM) && (beat_cnt_o < len_q);
  assign accept      = in_ready_o && in_valid_i;
  assign out_valid_o = (state == HOLD);
  assign busy_o      = (state != IDLE);
  assign cnt_inc     = beat_cnt_o + 1'b1;

  // Stage 0 captures the accepted beat; stage s holds NUM_IN>>s partial-sum vectors.
  for (genvar s = 0; s <= L; s++) begin : g_st
    localparam int N = NUM_IN >> s;
    logic [N*TILE_SIZE*WIDTH-1:0] data, nxt;
    logic                         en;
    if (s == 0) begin : g_in
      assign nxt = operand_i;
      assign en  = accept;
    end else begin : g_add
      assign en = vld[s-1];
      for (genvar k = 0; k < N; k++) begin : g_vec
        for (genvar j = 0; j < TILE_SIZE; j++) begin : g_lane
          assign nxt[(k*TILE_SIZE+j)*WIDTH +: WIDTH] =
            fp16_add(g_st[s-1].data[(2*k*TILE_SIZE+j)*WIDTH +: WIDTH],
                     g_st[s-1].data[((2*k+1)*TILE_SIZE+j)*WIDTH +: WIDTH]);
        end
      end
    end
    always_ff @(posedge CLK_i or negedge RST_ni) begin
      if (!RST_ni) data <= '0;
      else if (en) data <= nxt;
    end
  end

  for (genvar j = 0; j < TILE_SIZE; j++) begin : g_acc
    assign acc_sum[j*WIDTH +: WIDTH] = fp16_add(acc[j*WIDTH +: WIDTH], g_st[L].data[j*WIDTH +: WIDTH]);
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) vld <= '0;
    else if (clear_i) vld <= '0;
    else vld <= {vld[L-1:0], accept};
  end

  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      state       <= IDLE;
      acc         <= '0;
      len_q       <= '0;
      beat_cnt_o  <= '0;
      reduction_o <= '0;
    end else if (clear_i) begin
      state      <= IDLE;
      acc        <= '0;
      beat_cnt_o <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          acc        <= init_i;
          len_q      <= len_i;
          beat_cnt_o <= '0;
          if (len_i == '0) begin
            state       <= HOLD;
            reduction_o <= init_i;
          end else begin
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (vld[L]) acc <= acc_sum;
          if (accept) begin
            beat_cnt_o <= cnt_inc;
            if (cnt_inc == len_q) state <= DRAIN;
          end
        end
        DRAIN: if (vld[L]) begin
          acc <= acc_sum;
          // Nothing upstream means this is the last beat's sum.
          if (~|vld[L-1:0]) begin
            state       <= HOLD;
            reduction_o <= acc_sum;
          end
        end
        default: if (out_ready_i) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reduction_stream.sv
// Directed bench for reduction_stream with NUM_IN=4, TILE_SIZE=3.
module tb_reduction_stream;
  localparam int TS = 3;
  localparam int NI = 4;

  logic           clk, rst_n, clear, start, in_valid, out_ready;
  logic [15:0]    len;
  logic [TS*16-1:0]    init, red;
  logic [NI*TS*16-1:0] operand;
  logic           in_ready, out_valid, busy;
  logic [15:0]    beat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  reduction_stream #(.TILE_SIZE(TS), .NUM_IN(NI), .LEN_W(16)) dut (
    .CLK_i(clk), .RST_ni(rst_n), .clear_i(clear), .start_i(start), .len_i(len),
    .init_i(init), .in_valid_i(in_valid), .in_ready_o(in_ready), .operand_i(operand),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .reduction_o(red),
    .busy_o(busy), .beat_cnt_o(beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] init;
    logic [15:0] len;
    logic [63:0] ops;   // {op3, op2, op1, op0}, same value on every lane and beat
    logic [15:0] exp;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NI*TS*16-1:0] pack(input logic [63:0] o);
    logic [NI*TS*16-1:0] r;
    for (int k = 0; k < NI; k++)
      for (int j = 0; j < TS; j++)
        r[(k*TS+j)*16 +: 16] = o[k*16 +: 16];
    return r;
  endfunction

  task automatic begin_run(input logic [15:0] ini, input logic [15:0] ln);
    @(negedge clk);
    start = 1'b1; len = ln; init = {TS{ini}};
    @(negedge clk);
    start = 1'b0;
  endtask

  // gappy: after the k-th accepted beat, idle k cycles
  task automatic feed(input logic [63:0] ops, input logic [15:0] ln, input bit gappy);
    int n = 0;
    int guard = 0;
    operand = pack(ops);
    while (n < int'(ln) && guard < 200) begin
      in_valid = 1'b1;
      if (in_ready) n++;
      @(negedge clk);
      guard++;
      in_valid = 1'b0;
      if (gappy && n < int'(ln)) repeat (n) @(negedge clk);
    end
    in_valid = 1'b0;
    if (guard >= 200) chk("feed_timeout", 64'(n), 64'(ln));
  endtask

  task automatic wait_out(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_result(input logic [15:0] exp, input logic [15:0] ln);
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("busy_hold", 64'(busy), 64'd1);
    chk("beat_cnt", 64'(beat_cnt), 64'(ln));
    for (int j = 0; j < TS; j++) chk($sformatf("lane%0d", j), 64'(red[j*16 +: 16]), 64'(exp));
  endtask

  task automatic release_out(input logic [15:0] exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_valid", 64'(out_valid), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("kept_result", 64'(red[15:0]), 64'(exp));
  endtask

  task automatic full_run(input vec_t v, input bit gappy);
    begin_run(v.init, v.len);
    if (v.len == 16'd0) chk("no_ready", 64'(in_ready), 64'd0);
    feed(v.ops, v.len, gappy);
    if (v.len != 16'd0) chk("drain_ready", 64'(in_ready), 64'd0);
    wait_out((v.len == 16'd0) ? 0 : 3);
    check_result(v.exp, v.len);
  endtask

  initial begin
    vec_t g;
    bit seen;
    vt[0] = '{16'h0000, 16'd2, {4{16'h3c00}}, 16'h4800};
    vt[1] = '{16'h4200, 16'd0, {4{16'h3c00}}, 16'h4200};
    vt[2] = '{16'h3c00, 16'd3, {16'h4000, 16'h3c00, 16'h3800, 16'h3800}, 16'h4a80};
    vt[3] = '{16'h0000, 16'd1, {4{16'h3c00}}, 16'h4400};
    vt[4] = '{16'h4200, 16'd1, {16'hc000, 16'h4000, 16'h3c00, 16'hbc00}, 16'h4200};
    vt[5] = '{16'h0000, 16'd4, {4{16'h3800}}, 16'h4800};
    vt[6] = '{16'h3c00, 16'd2, {16'h0000, 16'h0000, 16'h7bff, 16'h7bff}, 16'h7c00};
    vt[7] = '{16'h0000, 16'd1, {16'h0000, 16'h0000, 16'h1000, 16'h3c01}, 16'h3c02};
    vt[8] = '{16'h0000, 16'd1, {16'h0000, 16'h0000, 16'h0001, 16'h0001}, 16'h0002};

    rst_n = 1'b0; clear = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; init = '0; operand = '0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_red", 64'(red), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      full_run(vt[i], 1'b0);
      release_out(vt[i].exp);
    end

    // Bubbles between beats, then a stalled result with start pulses ignored.
    g = vt[2];
    full_run(g, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2); len = 16'd1;
      @(negedge clk);
      start = 1'b0;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_red", 64'(red), {16'd0, {TS{g.exp}}});
    end
    chk("stall_busy", 64'(busy), 64'd1);
    start = 1'b1;
    release_out(g.exp);
    start = 1'b0;

    // Clear with a beat still in the tree.
    begin_run(16'h0000, 16'd1);
    feed({4{16'h3c00}}, 16'd1, 1'b0);
    chk("pre_clear_busy", 64'(busy), 64'd1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_cnt", 64'(beat_cnt), 64'd0);
    seen = out_valid;
    repeat (5) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("clear_no_valid", 64'(seen), 64'd0);
    full_run(vt[3], 1'b0);
    release_out(vt[3].exp);

    // Asynchronous reset in the middle of ACCUM.
    begin_run(16'h0000, 16'd4);
    operand = pack({4{16'h3c00}});
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd0);
    chk("arst_cnt", 64'(beat_cnt), 64'd0);
    chk("arst_red", 64'(red), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_run(vt[0], 1'b0);
    release_out(vt[0].exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
